// File: rtl/spi_image_pkg.sv
// -----------------------------------------------------------------------------
// spi_image_pkg
// Shared definitions for the SPI image slave: command byte values, the status
// byte returned while the slave or core is busy, and the command FSM state type.
// Optional feature macro: SPI_COST_CMD_EN (adds the LABEL state / cost command).
// -----------------------------------------------------------------------------
package spi_image_pkg;

   localparam logic [7:0] CMD_LOAD    = 8'h00;
   localparam logic [7:0] CMD_START   = 8'hFF;
   localparam logic [7:0] CMD_COST    = 8'h01;
   localparam logic [7:0] STATUS_BUSY = 8'hFF;
   localparam logic [7:0] STATUS_NONE = 8'h00;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      UNPACK
`ifdef SPI_COST_CMD_EN
      ,
      LABEL
`endif
   } state_t;

endpackage

// File: rtl/spi_pin_sync.sv
// -----------------------------------------------------------------------------
// spi_pin_sync
// Two-flop synchronisers for SCK, SS and MOSI followed by an edge-detect
// register, giving level outputs and single-cycle edge strobes in clk domain.
// Ports:
//   clk, n_rst           system clock, asynchronous active-low reset
//   sck, ss, mosi        raw SPI pins
//   ss_s, mosi_s         synchronised levels
//   sck_rise, sck_fall   SCK edge strobes
//   ss_rise, ss_fall     SS edge strobes
// -----------------------------------------------------------------------------
module spi_pin_sync (
   input  logic clk,
   input  logic n_rst,
   input  logic sck,
   input  logic ss,
   input  logic mosi,
   output logic ss_s,
   output logic mosi_s,
   output logic sck_rise,
   output logic sck_fall,
   output logic ss_rise,
   output logic ss_fall
);

   // Bit order {mosi, ss, sck}; SS resets to its idle-high level so that
   // leaving reset with the pin high produces no spurious frame start.
   localparam logic [2:0] IDLE_LEVEL = 3'b010;

   wire [2:0] pin_raw;
   wire [2:0] pin_sync;
   wire [2:0] pin_prev;

   assign pin_raw = {mosi, ss, sck};

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_sync
         logic meta_reg;
         logic sync_reg;
         logic prev_reg;

         always_ff @(posedge clk or negedge n_rst) begin
            if (!n_rst) begin
               meta_reg <= IDLE_LEVEL[gi];
               sync_reg <= IDLE_LEVEL[gi];
               prev_reg <= IDLE_LEVEL[gi];
            end else begin
               meta_reg <= pin_raw[gi];
               sync_reg <= meta_reg;
               prev_reg <= sync_reg;
            end
         end

         assign pin_sync[gi] = sync_reg;
         assign pin_prev[gi] = prev_reg;
      end
   endgenerate

   assign sck_rise = pin_sync[0] & ~pin_prev[0];
   assign sck_fall = ~pin_sync[0] & pin_prev[0];
   assign ss_rise  = pin_sync[1] & ~pin_prev[1];
   assign ss_fall  = ~pin_sync[1] & pin_prev[1];
   assign ss_s     = pin_sync[1];
   assign mosi_s   = pin_sync[2];

   // MOSI only needs its level; its delayed copy has no consumer.
   wire unused_mosi_prev = pin_prev[2];

endmodule

// File: rtl/spi_image_slave.sv
// -----------------------------------------------------------------------------
// spi_image_slave
// SPI slave front-end for the digit recogniser. Receives command bytes and
// packed pixel images (LSB first), unpacks each image byte into PPB one-pixel
// writes, starts classification and returns a status/result byte on MISO.
// Optional feature macro: SPI_COST_CMD_EN (cost request via command 0x01).
// Ports:
//   clk, n_rst              system clock, asynchronous active-low reset
//   SCK, SS, MOSI, MISO     SPI pins (mode 0, LSB first)
//   pix_we/pix_addr/pix_data  image buffer write port
//   start                   one-cycle classification start pulse
//   busy, result_valid, result  core status and digit result
//   cost_req, cost_label    cost request pulse and its label
//   cost_valid, cost        cost value returned by the core
// -----------------------------------------------------------------------------
module spi_image_slave
   import spi_image_pkg::*;
#(
   parameter int PIXEL_W    = 4,
   parameter int NUM_PIXELS = 144,
   parameter int AW         = $clog2(NUM_PIXELS)
) (
   input  logic               clk,
   input  logic               n_rst,
   input  logic               SCK,
   input  logic               SS,
   input  logic               MOSI,
   output logic               MISO,
   output logic               pix_we,
   output logic [AW-1:0]      pix_addr,
   output logic [PIXEL_W-1:0] pix_data,
   output logic               start,
   input  logic               busy,
   input  logic               result_valid,
   input  logic [7:0]         result,
   output logic               cost_req,
   output logic [7:0]         cost_label,
   input  logic               cost_valid,
   input  logic [7:0]         cost
);

   localparam int PPB   = 8 / PIXEL_W;
   localparam int SUB_W = (PPB > 1) ? $clog2(PPB) : 1;
   localparam logic [SUB_W-1:0] LAST_SUB = SUB_W'(PPB - 1);
   localparam logic [AW-1:0]    LAST_IDX = AW'(NUM_PIXELS - 1);

   // ---------------------------------------------------------------- pins
   logic ss_s, mosi_s, sck_rise, sck_fall, ss_rise, ss_fall;

   spi_pin_sync u_sync (
      .clk      (clk),
      .n_rst    (n_rst),
      .sck      (SCK),
      .ss       (SS),
      .mosi     (MOSI),
      .ss_s     (ss_s),
      .mosi_s   (mosi_s),
      .sck_rise (sck_rise),
      .sck_fall (sck_fall),
      .ss_rise  (ss_rise),
      .ss_fall  (ss_fall)
   );

   // ---------------------------------------------------------------- state
   state_t             state_reg, state_next;
   logic [2:0]         bit_cnt_reg;
   logic [7:0]         rx_reg;
   logic [7:0]         byte_reg;
   logic               byte_valid_reg;
   logic [7:0]         tx_reg;
   logic [7:0]         status;

   logic [7:0]         hold_reg, hold_next;
   logic [SUB_W-1:0]   sub_reg, sub_next;
   logic [AW-1:0]      pix_idx_reg, pix_idx_next;
   logic               image_ok_reg, image_ok_next;
   logic               pix_we_reg, pix_we_next;
   logic [AW-1:0]      pix_addr_reg, pix_addr_next;
   logic [PIXEL_W-1:0] pix_data_reg, pix_data_next;
   logic               start_reg, start_next;
   logic [1:0]         pend_reg, pend_next;
   logic               res_valid_reg, res_valid_next;
   logic [7:0]         res_reg, res_next;
   logic               rvd_reg;
`ifdef SPI_COST_CMD_EN
   logic               armed_reg, armed_next;
   logic               cost_req_reg, cost_req_next;
   logic [7:0]         cost_label_reg, cost_label_next;
`endif

   // ---------------------------------------------------------------- status
   // Later assignments take priority: armed cost read, then busy, then result.
   always_comb begin
      status = STATUS_NONE;
      if (res_valid_reg)
         status = res_reg;
      if (state_reg == LOAD || state_reg == UNPACK || busy || pend_reg != 2'd0)
         status = STATUS_BUSY;
`ifdef SPI_COST_CMD_EN
      if (armed_reg)
         status = cost_valid ? cost : STATUS_BUSY;
`endif
   end

   // ---------------------------------------------------------------- framing
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         bit_cnt_reg    <= 3'd0;
         rx_reg         <= 8'h00;
         byte_reg       <= 8'h00;
         byte_valid_reg <= 1'b0;
         tx_reg         <= 8'h00;
      end else begin
         byte_valid_reg <= 1'b0;
         if (ss_fall) begin
            bit_cnt_reg <= 3'd0;
            tx_reg      <= status;
         end else if (ss_rise) begin
            // A partial byte at frame end is simply dropped.
            bit_cnt_reg <= 3'd0;
         end else if (!ss_s) begin
            if (sck_rise) begin
               rx_reg      <= {mosi_s, rx_reg[7:1]};
               bit_cnt_reg <= bit_cnt_reg + 3'd1;
               if (bit_cnt_reg == 3'd7) begin
                  byte_valid_reg <= 1'b1;
                  byte_reg       <= {mosi_s, rx_reg[7:1]};
               end
            end
            // Reload and shift never coincide: a falling edge is at least
            // four clk cycles after the rising edge that completed the byte.
            if (byte_valid_reg)
               tx_reg <= status;
            else if (sck_fall)
               tx_reg <= {1'b0, tx_reg[7:1]};
         end
      end
   end

   assign MISO = tx_reg[0] & ~ss_s;

   // ---------------------------------------------------------------- FSM regs
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_reg      <= IDLE;
         hold_reg       <= 8'h00;
         sub_reg        <= '0;
         pix_idx_reg    <= '0;
         image_ok_reg   <= 1'b0;
         pix_we_reg     <= 1'b0;
         pix_addr_reg   <= '0;
         pix_data_reg   <= '0;
         start_reg      <= 1'b0;
         pend_reg       <= 2'd0;
         res_valid_reg  <= 1'b0;
         res_reg        <= 8'h00;
         rvd_reg        <= 1'b0;
`ifdef SPI_COST_CMD_EN
         armed_reg      <= 1'b0;
         cost_req_reg   <= 1'b0;
         cost_label_reg <= 8'h00;
`endif
      end else begin
         state_reg      <= state_next;
         hold_reg       <= hold_next;
         sub_reg        <= sub_next;
         pix_idx_reg    <= pix_idx_next;
         image_ok_reg   <= image_ok_next;
         pix_we_reg     <= pix_we_next;
         pix_addr_reg   <= pix_addr_next;
         pix_data_reg   <= pix_data_next;
         start_reg      <= start_next;
         pend_reg       <= pend_next;
         res_valid_reg  <= res_valid_next;
         res_reg        <= res_next;
         rvd_reg        <= result_valid;
`ifdef SPI_COST_CMD_EN
         armed_reg      <= armed_next;
         cost_req_reg   <= cost_req_next;
         cost_label_reg <= cost_label_next;
`endif
      end
   end

   // ---------------------------------------------------------------- FSM comb
   always_comb begin
      state_next      = state_reg;
      hold_next       = hold_reg;
      sub_next        = sub_reg;
      pix_idx_next    = pix_idx_reg;
      image_ok_next   = image_ok_reg;
      pix_we_next     = 1'b0;
      pix_addr_next   = pix_addr_reg;
      pix_data_next   = pix_data_reg;
      start_next      = 1'b0;
      pend_next       = pend_reg;
      res_valid_next  = res_valid_reg;
      res_next        = res_reg;
`ifdef SPI_COST_CMD_EN
      armed_next      = armed_reg;
      cost_req_next   = 1'b0;
      cost_label_next = cost_label_reg;
`endif

      // A start stays pending until the core reports busy, with a short
      // timeout so a core that never responds cannot lock the status.
      if (busy)
         pend_next = 2'd0;
      else if (pend_reg != 2'd0)
         pend_next = pend_reg - 2'd1;

      // Capture on the rising edge of result_valid, and follow the value
      // while held; a load command clears it and it stays clear until the
      // next fresh result.
      if (result_valid && (!rvd_reg || res_valid_reg)) begin
         res_valid_next = 1'b1;
         res_next       = result;
      end

      case (state_reg)
         IDLE: begin
            if (byte_valid_reg) begin
               if (byte_reg == CMD_LOAD) begin
                  state_next     = LOAD;
                  pix_idx_next   = '0;
                  image_ok_next  = 1'b0;
                  res_valid_next = 1'b0;
`ifdef SPI_COST_CMD_EN
                  armed_next     = 1'b0;
`endif
               end else if (byte_reg == CMD_START) begin
`ifdef SPI_COST_CMD_EN
                  armed_next = 1'b0;
`endif
                  if (image_ok_reg && !busy && pend_reg == 2'd0) begin
                     start_next = 1'b1;
                     pend_next  = 2'd3;
                  end
               end
`ifdef SPI_COST_CMD_EN
               else if (byte_reg == CMD_COST) begin
                  state_next = LABEL;
               end
`endif
            end
         end

         LOAD: begin
            if (byte_valid_reg) begin
               hold_next  = byte_reg;
               sub_next   = '0;
               state_next = UNPACK;
            end
         end

         UNPACK: begin
            // Low-order pixel first: emit the bottom field, then shift down.
            pix_we_next   = 1'b1;
            pix_addr_next = pix_idx_reg;
            pix_data_next = hold_reg[PIXEL_W-1:0];
            hold_next     = hold_reg >> PIXEL_W;
            pix_idx_next  = pix_idx_reg + AW'(1);
            sub_next      = sub_reg + SUB_W'(1);
            if (sub_reg == LAST_SUB) begin
               if (pix_idx_reg == LAST_IDX) begin
                  image_ok_next = 1'b1;
                  state_next    = IDLE;
               end else begin
                  state_next = LOAD;
               end
            end
         end

`ifdef SPI_COST_CMD_EN
         LABEL: begin
            if (byte_valid_reg) begin
               cost_label_next = byte_reg;
               cost_req_next   = 1'b1;
               armed_next      = 1'b1;
               state_next      = IDLE;
            end
         end
`endif

         default: state_next = IDLE;
      endcase
   end

   // ---------------------------------------------------------------- outputs
   assign pix_we   = pix_we_reg;
   assign pix_addr = pix_addr_reg;
   assign pix_data = pix_data_reg;
   assign start    = start_reg;

`ifdef SPI_COST_CMD_EN
   assign cost_req   = cost_req_reg;
   assign cost_label = cost_label_reg;
`else
   assign cost_req   = 1'b0;
   assign cost_label = 8'h00;
   wire unused_cost = ^{cost_valid, cost};
`endif

endmodule

// File: tb/tb_spi_image_slave.sv
// -----------------------------------------------------------------------------
// tb_spi_image_slave
// Directed bench for spi_image_slave: drives SPI frames as a master, keeps an
// expected-pixel queue filled as image bytes are sent and compares it with the
// writes recorded by a monitor, and checks MISO status bytes and pulses.
// Honours SPI_COST_CMD_EN when the design is built with it.
// -----------------------------------------------------------------------------
module tb_spi_image_slave;

   localparam int PIXEL_W    = 4;
   localparam int NUM_PIXELS = 144;
   localparam int AW         = 8;
   localparam int PPB        = 8 / PIXEL_W;
   localparam int NBYTES     = NUM_PIXELS / PPB;
   localparam int HALF       = 8;

`ifdef SPI_COST_CMD_EN
   localparam bit COST_EN = 1'b1;
`else
   localparam bit COST_EN = 1'b0;
`endif

   logic               clk = 1'b0;
   logic               n_rst = 1'b0;
   logic               SCK = 1'b0;
   logic               SS = 1'b1;
   logic               MOSI = 1'b0;
   logic               MISO;
   logic               pix_we;
   logic [AW-1:0]      pix_addr;
   logic [PIXEL_W-1:0] pix_data;
   logic               start;
   logic               busy = 1'b0;
   logic               result_valid = 1'b0;
   logic [7:0]         result = 8'h00;
   logic               cost_req;
   logic [7:0]         cost_label;
   logic               cost_valid = 1'b0;
   logic [7:0]         cost = 8'h00;

   spi_image_slave #(
      .PIXEL_W    (PIXEL_W),
      .NUM_PIXELS (NUM_PIXELS),
      .AW         (AW)
   ) dut (
      .clk          (clk),
      .n_rst        (n_rst),
      .SCK          (SCK),
      .SS           (SS),
      .MOSI         (MOSI),
      .MISO         (MISO),
      .pix_we       (pix_we),
      .pix_addr     (pix_addr),
      .pix_data     (pix_data),
      .start        (start),
      .busy         (busy),
      .result_valid (result_valid),
      .result       (result),
      .cost_req     (cost_req),
      .cost_label   (cost_label),
      .cost_valid   (cost_valid),
      .cost         (cost)
   );

   always #5 clk = ~clk;

   // ---------------------------------------------------------------- monitor
   logic [15:0] obs_mem [0:1023];
   int          obs_wr = 0;
   int          start_cnt = 0;
   int          costreq_cnt = 0;

   always @(negedge clk) begin
      if (pix_we && obs_wr < 1024) begin
         obs_mem[obs_wr] <= {pix_addr, 4'h0, pix_data};
         obs_wr          <= obs_wr + 1;
      end
      if (start)
         start_cnt <= start_cnt + 1;
      if (cost_req)
         costreq_cnt <= costreq_cnt + 1;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // ---------------------------------------------------------------- checks
   int          total = 0;
   int          bad = 0;
   logic [15:0] exp_q[$];
   int          rd_ptr = 0;
   logic [7:0]  exp_idx = 8'h00;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
      rx = 8'h00;
      SS = 1'b0;
      for (int i = 0; i < 8; i++) begin
         MOSI = tx[i];
         repeat (HALF) @(negedge clk);
         rx[i] = MISO;
         SCK = 1'b1;
         repeat (HALF) @(negedge clk);
         SCK = 1'b0;
      end
      repeat (HALF) @(negedge clk);
      SS = 1'b1;
      repeat (12) @(negedge clk);
   endtask

   task automatic send_chk(input string tag, input logic [7:0] tx, input logic [7:0] exp_rx);
      logic [7:0] rx;
      xfer(tx, rx);
      chk(tag, {24'h0, rx}, {24'h0, exp_rx});
   endtask

   task automatic drain();
      logic [15:0] e;
      chk("pix_count", obs_wr - rd_ptr, exp_q.size());
      while (rd_ptr < obs_wr && exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("pix_write", {16'h0, obs_mem[rd_ptr]}, {16'h0, e});
         rd_ptr++;
      end
      rd_ptr = obs_wr;
      exp_q.delete();
   endtask

   task automatic load_byte(input logic [7:0] b);
      for (int k = 0; k < PPB; k++) begin
         exp_q.push_back({exp_idx, 4'h0, b[k*PIXEL_W +: PIXEL_W]});
         exp_idx = exp_idx + 8'd1;
      end
      send_chk("load_miso", b, 8'hFF);
      drain();
   endtask

   task automatic load_image(input logic [7:0] cmd_status);
      int base;
      logic [7:0] b;
      rd_ptr  = obs_wr;
      base    = obs_wr;
      exp_idx = 8'h00;
      send_chk("load_cmd_miso", 8'h00, cmd_status);
      for (int i = 0; i < NBYTES; i++) begin
         b = (i == 0) ? 8'h21 : 8'($urandom_range(0, 255));
         load_byte(b);
      end
      chk("pix_total", obs_wr - base, NUM_PIXELS);
   endtask

   // ---------------------------------------------------------------- sequence
   initial begin
      int sc;
      int cc;
      int snap;
      logic [7:0] rx;
      bit found;

      repeat (4) @(negedge clk);
      chk("rst_pix_we", {31'h0, pix_we}, 0);
      chk("rst_pix_addr", {24'h0, pix_addr}, 0);
      chk("rst_pix_data", {28'h0, pix_data}, 0);
      chk("rst_start", {31'h0, start}, 0);
      chk("rst_cost_req", {31'h0, cost_req}, 0);
      chk("rst_cost_label", {24'h0, cost_label}, 0);
      chk("rst_miso", {31'h0, MISO}, 0);
      n_rst = 1'b1;
      repeat (5) @(negedge clk);

      // First read after reset; 0xFF with no image must not start.
      sc = start_cnt;
      send_chk("rd_reset", 8'hFF, 8'h00);
      chk("no_start_noimg", start_cnt - sc, 0);

      // Aborted frame after 5 bits, then a full image load.
      SS = 1'b0;
      for (int i = 0; i < 5; i++) begin
         MOSI = 1'b1;
         repeat (HALF) @(negedge clk);
         SCK = 1'b1;
         repeat (HALF) @(negedge clk);
         SCK = 1'b0;
      end
      repeat (HALF) @(negedge clk);
      SS = 1'b1;
      repeat (12) @(negedge clk);
      load_image(8'h00);

      // Start with image loaded and core idle.
      sc = start_cnt;
      send_chk("rd_idle", 8'hFF, 8'h00);
      chk("one_start", start_cnt - sc, 1);

      busy = 1'b1;
      send_chk("rd_busy", 8'h55, 8'hFF);
      sc = start_cnt;
      send_chk("rd_busy_start", 8'hFF, 8'hFF);
      chk("no_start_busy", start_cnt - sc, 0);

      busy = 1'b0;
      result = 8'd7;
      result_valid = 1'b1;
      repeat (4) @(negedge clk);
      send_chk("rd_result", 8'h55, 8'h07);

      // Cost command sequence.
      cc = costreq_cnt;
      send_chk("rd_cost_cmd", 8'h01, 8'h07);
      send_chk("rd_label", 8'h07, 8'h07);
      cost = 8'd42;
      cost_valid = 1'b1;
      repeat (4) @(negedge clk);
      send_chk("rd_cost", 8'h55, COST_EN ? 8'd42 : 8'h07);
      chk("cost_req_cnt", costreq_cnt - cc, COST_EN ? 1 : 0);
      chk("cost_label", {24'h0, cost_label}, COST_EN ? 7 : 0);

      // Reset in the middle of unpacking a byte.
      send_chk("rd_pre_load", 8'h00, COST_EN ? 8'd42 : 8'h07);
      snap  = 0;
      found = 1'b0;
      fork
         xfer(8'hA5, rx);
         begin
            for (int i = 0; i < 400; i++) begin
               @(negedge clk);
               if (pix_we) begin
                  found = 1'b1;
                  break;
               end
            end
            n_rst = 1'b0;
            #1;
            chk("rst_wait_we", {31'h0, found}, 1);
            chk("rst_we_drop", {31'h0, pix_we}, 0);
            chk("rst_start_low", {31'h0, start}, 0);
            busy = 1'b0;
            result_valid = 1'b0;
            cost_valid = 1'b0;
            repeat (2) @(negedge clk);
            snap = obs_wr;
            repeat (4) @(negedge clk);
            n_rst = 1'b1;
         end
      join
      chk("no_write_after_rst", obs_wr, snap);
      rd_ptr = obs_wr;

      // Reset cleared image_ok: no start, and reload restarts at address 0.
      sc = start_cnt;
      send_chk("rd_after_rst", 8'hFF, 8'h00);
      chk("no_start_after_rst", start_cnt - sc, 0);
      load_image(8'h00);
      sc = start_cnt;
      send_chk("rd_restart", 8'hFF, 8'h00);
      chk("restart_start", start_cnt - sc, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
